tlc_lamp_monitor: RTL

TLC_LAMP_MONITOR -- requirements
Module: tlc_lamp_monitor

---
 rtl/tlc_lamp_monitor.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tlc_lamp_monitor.sv
// ============================================================================
//  Module      : tlc_lamp_monitor
//  Description : Watches the six lamp drives of a two-direction traffic light
//                controller and checks three things about them:
//                  * illegal lamp combinations (conflict),
//                  * phase ordering G1->Y1->RA->G2->Y2->RB->G1 (sequence),
//                  * minimum green / yellow dwell times (dwell).
//                Errors are sticky until err_clr. Each cycle that raises at
//                least one new violation adds one to a saturating counter.
//  Ports       : blif_clk_net    - clock, rising edge
//                blif_reset_net  - asynchronous active-high reset
//                en              - monitor enable
//                GRN1/YLW1/RED1  - direction-1 lamp drives
//                GRN2/YLW2/RED2  - direction-2 lamp drives
//                err_clr         - synchronous clear of flags and count
//                phase           - tracked phase code (0 = IDLE)
//                dwell           - cycles in current phase, saturating
//                err_conflict/err_seq/err_dwell - sticky error flags
//                viol_cnt        - saturating violation-cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_lamp_monitor #(
    parameter int MIN_GRN = 8,
    parameter int MIN_YLW = 3
) (
    input  logic       blif_clk_net,
    input  logic       blif_reset_net,
    input  logic       en,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    input  logic       err_clr,
    output logic [2:0] phase,
    output logic [7:0] dwell,
    output logic       err_conflict,
    output logic       err_seq,
    output logic       err_dwell,
    output logic [7:0] viol_cnt
);

    // Tracked phases
    localparam logic [2:0] c_ph_idle = 3'd0;
    localparam logic [2:0] c_ph_g1   = 3'd1;
    localparam logic [2:0] c_ph_y1   = 3'd2;
    localparam logic [2:0] c_ph_ra   = 3'd3;
    localparam logic [2:0] c_ph_g2   = 3'd4;
    localparam logic [2:0] c_ph_y2   = 3'd5;
    localparam logic [2:0] c_ph_rb   = 3'd6;

    // Decoded lamp states; codes chosen to match the phase they resync to
    localparam logic [2:0] c_ds_ill  = 3'd0;
    localparam logic [2:0] c_ds_g1   = 3'd1;
    localparam logic [2:0] c_ds_y1   = 3'd2;
    localparam logic [2:0] c_ds_ar   = 3'd3;
    localparam logic [2:0] c_ds_g2   = 3'd4;
    localparam logic [2:0] c_ds_y2   = 3'd5;

    localparam logic [7:0] c_min_grn = 8'(MIN_GRN);
    localparam logic [7:0] c_min_ylw = 8'(MIN_YLW);
    localparam logic [7:0] c_sat     = 8'hFF;

    // Registered lamps: {G1, Y1, R1, G2, Y2, R2}
    logic [5:0] r_lamps;
    logic [2:0] r_phase;
    logic [7:0] r_dwell;
    logic       r_exempt;
    logic       r_err_conflict;
    logic       r_err_seq;
    logic       r_err_dwell;
    logic [7:0] r_viol_cnt;

    logic [2:0] w_ds;
    logic       w_leg1;
    logic       w_leg2;
    logic       w_cur_idle;
    logic [2:0] w_next_phase;
    logic       w_conf;
    logic       w_seq;
    logic       w_dwv;
    logic       w_any;
    logic       w_phase_chg;

    // Decoded state that means "stay in this phase"
    function automatic logic [2:0] hold_ds(input logic [2:0] ph);
        case (ph)
            c_ph_g1: hold_ds = c_ds_g1;
            c_ph_y1: hold_ds = c_ds_y1;
            c_ph_ra: hold_ds = c_ds_ar;
            c_ph_g2: hold_ds = c_ds_g2;
            c_ph_y2: hold_ds = c_ds_y2;
            c_ph_rb: hold_ds = c_ds_ar;
            default: hold_ds = c_ds_ill;
        endcase
    endfunction

    // Decoded state of the legal successor phase
    function automatic logic [2:0] succ_ds(input logic [2:0] ph);
        case (ph)
            c_ph_g1: succ_ds = c_ds_y1;
            c_ph_y1: succ_ds = c_ds_ar;
            c_ph_ra: succ_ds = c_ds_g2;
            c_ph_g2: succ_ds = c_ds_y2;
            c_ph_y2: succ_ds = c_ds_ar;
            c_ph_rb: succ_ds = c_ds_g1;
            default: succ_ds = c_ds_ill;
        endcase
    endfunction

    // Phase a legal decoded state lands in when the ordering is lost;
    // all-red carries no direction history so it falls back to IDLE
    function automatic logic [2:0] resync_ph(input logic [2:0] ds);
        case (ds)
            c_ds_g1: resync_ph = c_ph_g1;
            c_ds_y1: resync_ph = c_ph_y1;
            c_ds_g2: resync_ph = c_ph_g2;
            c_ds_y2: resync_ph = c_ph_y2;
            default: resync_ph = c_ph_idle;
        endcase
    endfunction

    // Lamp decode
    always_comb begin
        w_leg1 = ({1'b0, r_lamps[5]} + {1'b0, r_lamps[4]} + {1'b0, r_lamps[3]}) == 2'd1;
        w_leg2 = ({1'b0, r_lamps[2]} + {1'b0, r_lamps[1]} + {1'b0, r_lamps[0]}) == 2'd1;
        w_ds   = c_ds_ill;
        if (w_leg1 && w_leg2) begin
            if (r_lamps[3] && r_lamps[0])      w_ds = c_ds_ar;
            else if (r_lamps[0] && r_lamps[5]) w_ds = c_ds_g1;
            else if (r_lamps[0] && r_lamps[4]) w_ds = c_ds_y1;
            else if (r_lamps[3] && r_lamps[2]) w_ds = c_ds_g2;
            else if (r_lamps[3] && r_lamps[1]) w_ds = c_ds_y2;
            else                               w_ds = c_ds_ill;  // both non-red
        end
    end

    // Phase tracking and violation detection
    always_comb begin
        w_cur_idle   = (r_phase == c_ph_idle) || (r_phase == 3'd7);
        w_next_phase = w_cur_idle ? c_ph_idle : r_phase;
        w_conf       = 1'b0;
        w_seq        = 1'b0;
        w_dwv        = 1'b0;
        if (!en) begin
            w_next_phase = c_ph_idle;
        end else if (w_ds == c_ds_ill) begin
            w_conf       = 1'b1;
            w_next_phase = c_ph_idle;
        end else if (w_cur_idle) begin
            w_next_phase = resync_ph(w_ds);
        end else if (w_ds != hold_ds(r_phase)) begin
            if (w_ds == succ_ds(r_phase)) begin
                w_next_phase = (r_phase == c_ph_rb) ? c_ph_g1 : r_phase + 3'd1;
            end else begin
                w_seq        = 1'b1;
                w_next_phase = resync_ph(w_ds);
            end
            // Exit dwell check; skipped for the partial phase seen first
            if (!r_exempt) begin
                if (((r_phase == c_ph_g1) || (r_phase == c_ph_g2)) && (r_dwell < c_min_grn))
                    w_dwv = 1'b1;
                if (((r_phase == c_ph_y1) || (r_phase == c_ph_y2)) && (r_dwell < c_min_ylw))
                    w_dwv = 1'b1;
            end
        end
        w_any       = w_conf || w_seq || w_dwv;
        w_phase_chg = (w_next_phase != r_phase);
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_lamps        <= 6'd0;
            r_phase        <= c_ph_idle;
            r_dwell        <= 8'd0;
            r_exempt       <= 1'b1;
            r_err_conflict <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_dwell    <= 1'b0;
            r_viol_cnt     <= 8'd0;
        end else begin
            r_lamps <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
            r_phase <= w_next_phase;

            if (!en)
                r_dwell <= 8'd0;
            else if (w_phase_chg)
                r_dwell <= 8'd1;
            else if (r_dwell != c_sat)
                r_dwell <= r_dwell + 8'd1;

            // Every visit to IDLE re-arms the exemption for the next entry
            if (w_next_phase == c_ph_idle)
                r_exempt <= 1'b1;
            else if (w_phase_chg && !w_cur_idle)
                r_exempt <= 1'b0;

            // A new violation overrides a simultaneous clear
            r_err_conflict <= (r_err_conflict && !err_clr) || w_conf;
            r_err_seq      <= (r_err_seq      && !err_clr) || w_seq;
            r_err_dwell    <= (r_err_dwell    && !err_clr) || w_dwv;

            if (err_clr)
                r_viol_cnt <= {7'd0, w_any};
            else if (w_any && (r_viol_cnt != c_sat))
                r_viol_cnt <= r_viol_cnt + 8'd1;
        end
    end

    assign phase        = r_phase;
    assign dwell        = r_dwell;
    assign err_conflict = r_err_conflict;
    assign err_seq      = r_err_seq;
    assign err_dwell    = r_err_dwell;
    assign viol_cnt     = r_viol_cnt;

endmodule

`default_nettype wire
